// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV64I fields back into 32-bit instruction
// words, one per cycle, each tagged with a byte address and an error flag.
// A single-entry output register with valid/ready handshake holds the word.
// Optional build macro ENC_RANGE_CHECK_EN enables immediate range checking,
// out_err and err_cnt; without it both are tied to zero.
module instr_encoder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  input  logic             pc_load,
  input  logic [31:0]      pc_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        is_shift;
  logic [31:0] enc_word;
  logic        enc_err;
  logic [31:0] pc;
  logic [31:0] load_addr;

  assign in_ready  = (state == EMPTY) || out_ready;
  assign out_valid = (state == FULL);
  assign accept    = in_valid && in_ready;
  assign load_addr = {pc_value[31:2], 2'b00};
  assign is_shift  = (in_opcode == OP_IMM) &&
                     ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

  // Pack the fields according to the format selected by the opcode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    enc_word = NOP_WORD;
    case (in_opcode)
      OP_R:
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_LOAD, OP_JALR, OP_SYSTEM:
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_IMM:
        if (is_shift)
          enc_word = {in_funct7[6:1], in_imm[5:0], in_rs1, in_funct3, in_rd, in_opcode};
        else
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_STORE:
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_BRANCH:
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      OP_LUI, OP_AUIPC:
        enc_word = {in_imm[31:12], in_rd, in_opcode};
      OP_JAL:
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default:
        enc_word = NOP_WORD;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic sx11, sx12, sx20;

  // Flag immediates that do not survive truncation into their field.
  always_comb begin
    sx11    = (&in_imm[31:11]) || !(|in_imm[31:11]);
    sx12    = (&in_imm[31:12]) || !(|in_imm[31:12]);
    sx20    = (&in_imm[31:20]) || !(|in_imm[31:20]);
    enc_err = 1'b1;
    case (in_opcode)
      OP_R:                         enc_err = 1'b0;
      OP_LOAD, OP_JALR, OP_SYSTEM,
      OP_STORE:                     enc_err = !sx11;
      OP_IMM:                       enc_err = is_shift ? (|in_imm[31:6]) : !sx11;
      OP_BRANCH:                    enc_err = !sx12 || in_imm[0];
      OP_LUI, OP_AUIPC:             enc_err = |in_imm[11:0];
      OP_JAL:                       enc_err = !sx20 || in_imm[0];
      default:                      enc_err = 1'b1;
    endcase
  end

  // Count flagged words, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (accept && enc_err && !(&err_cnt))
      err_cnt <= err_cnt + CNT_ONE;
  end
`else
  assign enc_err = 1'b0;
  assign err_cnt = '0;
`endif

  // Output register occupancy: advance the EMPTY/FULL state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n)
      state <= EMPTY;
    else
      state <= state_next;
  end

  // Next occupancy from the accept and drain handshakes.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Capture the encoded word with its address; track the next address.
  always_ff @(posedge clk) begin
    // NOTE: output registers are reset because their reset values are observable; a reset drops a held word.
    if (!rst_n) begin
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      pc        <= RESET_PC;
    end else begin
      if (accept) begin
        out_instr <= enc_word;
        out_addr  <= pc_load ? load_addr : pc;
        out_err   <= enc_err;
      end
      if (pc_load)
        pc <= load_addr + (accept ? 32'd4 : 32'd0);
      else if (accept)
        pc <= pc + 32'd4;
    end
  end

  // Count accepted words; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)
      instr_cnt <= '0;
    else if (accept)
      instr_cnt <= instr_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized + directed bench for instr_encoder with a
// scoreboard queue filled at acceptance and drained by a separate monitor.
module tb_instr_encoder;

  localparam int CNT_W = 16;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, in_valid, in_ready, pc_load, out_valid, out_ready, out_err;
  logic [6:0]       in_opcode, in_funct7;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [31:0]      in_imm, pc_value, out_instr, out_addr;
  logic [CNT_W-1:0] instr_cnt, err_cnt;

  instr_encoder #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .pc_load(pc_load), .pc_value(pc_value), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .instr_cnt(instr_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic        legal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_pc;
  int          m_cnt, m_err;

  logic [6:0] ops [10] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                           7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // True when v, read as a signed value, fits in a signed field of 'bits' bits.
  function automatic bit fits(input logic [31:0] v, input int bits);
    int s;
    s = $signed(v);
    return (s >= -(1 << (bits - 1))) && (s < (1 << (bits - 1)));
  endfunction

  // Reference encoder: format layout plus arithmetic legality of the immediate.
  function automatic void model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                output logic [31:0] w, output logic bad);
    case (op)
      7'b0110011: begin w = {f7, rs2, rs1, f3, rd, op}; bad = 1'b0; end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        w = {imm[11:0], rs1, f3, rd, op}; bad = !fits(imm, 12);
      end
      7'b0010011:
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w = {f7[6:1], imm[5:0], rs1, f3, rd, op}; bad = (imm >= 32'd64);
        end else begin
          w = {imm[11:0], rs1, f3, rd, op}; bad = !fits(imm, 12);
        end
      7'b0100011: begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; bad = !fits(imm, 12); end
      7'b1100011: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        bad = !fits(imm, 13) || imm[0];
      end
      7'b0110111, 7'b0010111: begin w = {imm[31:12], rd, op}; bad = (imm % 4096) != 0; end
      7'b1101111: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        bad = !fits(imm, 21) || imm[0];
      end
      default: begin w = 32'h0000_0013; bad = 1'b1; end
    endcase
  endfunction

  // Independent decoder used to confirm the immediate round-trips.
  function automatic logic [31:0] decode_imm(input logic [31:0] w);
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return {{20{w[31]}}, w[31:20]};
      7'b0100011: return {{20{w[31]}}, w[31:25], w[11:7]};
      7'b1100011: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'b0110111, 7'b0010111: return {w[31:12], 12'b0};
      7'b1101111: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Present one field bundle until accepted. stall<0: random out_ready;
  // stall>=0: out_ready low for 'stall' cycles, then high.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input logic ld, input logic [31:0] pv, input int stall,
                      input bit use_k, input logic [31:0] k);
    logic [31:0] w;
    logic        bad;
    exp_t        e;
    int          n;
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1; pc_load = ld; pc_value = pv;
    n = 0;
    forever begin
      if (stall < 0) out_ready = ($urandom_range(0, 3) != 0);
      else           out_ready = (n >= stall);
      @(negedge clk);
      if (stall > 0 && n < stall) check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      if (in_ready) begin
        model(op, rd, rs1, rs2, f3, f7, imm, w, bad);
        e.instr  = use_k ? k : w;
        e.addr   = ld ? {pv[31:2], 2'b00} : m_pc;
        e.err    = CHK && bad;
        e.legal  = !bad;
        e.opcode = op; e.funct3 = f3; e.imm = imm;
        sb.push_back(e);
        m_pc = e.addr + 32'd4;
        m_cnt++;
        if (bad) m_err++;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    pc_load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_rand();
    logic [31:0] x, imm;
    logic [6:0]  op;
    bit          ld;
    x  = $urandom;
    op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
    case ($urandom_range(0, 5))
      0: imm = $urandom;
      1: imm = {{20{x[11]}}, x[11:0]};
      2: imm = {{19{x[12]}}, x[12:1], 1'b0};
      3: imm = {{11{x[20]}}, x[20:1], 1'b0};
      4: imm = {x[31:12], 12'b0};
      default: imm = x & 32'd63;
    endcase
    ld = ($urandom_range(0, 15) == 0);
    send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
         imm, ld, $urandom, -1, 1'b0, 32'h0);
  endtask

  // Monitor: pop and compare on every output transfer; check stall stability.
  logic        held = 1'b0;
  logic [31:0] h_instr, h_addr;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        check("stall_instr", out_instr, h_instr);
        check("stall_addr", out_addr, h_addr);
      end
      if (out_valid && !out_ready) begin
        held = 1'b1; h_instr = out_instr; h_addr = out_addr;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got %h with nothing expected", out_instr);
        end else begin
          e = sb.pop_front();
          check("out_instr", out_instr, e.instr);
          check("out_addr", out_addr, e.addr);
          check("out_err", {31'b0, out_err}, {31'b0, e.err});
          if (e.legal && e.opcode != 7'b0110011 &&
              !(e.opcode == 7'b0010011 && (e.funct3 == 3'd1 || e.funct3 == 3'd5)))
            check("roundtrip_imm", decode_imm(out_instr), e.imm);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pc_load = 1'b0; pc_value = '0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
    in_funct7 = '0; in_imm = '0;
    m_pc = 32'h0; m_cnt = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_instr_cnt", 32'(instr_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Back-to-back legal words with known encodings.
    send(7'b0110011, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,   1'b0, 32'h0, 0, 1'b1, 32'h002080b3);
    send(7'b0010011, 5'd5, 5'd4, 5'd0, 3'd0, 7'd0, 32'd100, 1'b0, 32'h0, 0, 1'b1, 32'h06420293);
    send(7'b0000011, 5'd7, 5'd6, 5'd0, 3'd2, 7'd0, 32'd8,   1'b0, 32'h0, 0, 1'b1, 32'h00832383);
    send(7'b0100011, 5'd0, 5'd8, 5'd9, 3'd2, 7'd0, 32'd12,  1'b0, 32'h0, 0, 1'b1, 32'h00942623);
    send(7'b1100011, 5'd0, 5'd10, 5'd11, 3'd0, 7'd0, 32'd16, 1'b0, 32'h0, 0, 1'b1, 32'h00b50863);
    idle(3);
    check("cnt_after_directed", 32'(instr_cnt), 32'd5);
    check("err_after_directed", 32'(err_cnt), 32'd0);

    // Range errors.
    send(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b0, 32'h0, 0, 1'b1, 32'h80000013);
    idle(2);
    check("err_cnt_first", 32'(err_cnt), CHK ? 32'd1 : 32'd0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    send(7'h7f, 5'd3, 5'd4, 5'd5, 3'd1, 7'd2, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'h00000013);
    idle(3);
    check("err_cnt_range", 32'(err_cnt), CHK ? 32'd3 : 32'd0);

    // Backpressure: 3 stalled cycles, then the waiting word goes in at release.
    send(7'b0110011, 5'd3, 5'd4, 5'd5, 3'd7, 7'd0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    send(7'b0110111, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b0, 32'h0, 3, 1'b0, 32'h0);
    idle(3);

    // Address reload while idle, then coincident with an accept.
    pc_load = 1'b1; pc_value = 32'h1000;
    @(posedge clk); #1;
    pc_load = 1'b0; m_pc = 32'h1000;
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd63, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 1'b1, 32'h2003, 0, 1'b0, 32'h0);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFFF000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    idle(3);
    check("cnt_before_random", 32'(instr_cnt), 32'(m_cnt));

    // Randomized traffic with random backpressure and occasional reloads.
    for (int i = 0; i < 300; i++) send_rand();
    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("cnt_after_random", 32'(instr_cnt), 32'(m_cnt));
    check("err_after_random", 32'(err_cnt), CHK ? 32'(m_err) : 32'd0);

    // Reset while a word is held under backpressure.
    send(7'b0110011, 5'd7, 5'd7, 5'd7, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_instr", out_instr, 32'd0);
    check("midrst_instr_cnt", 32'(instr_cnt), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    m_pc = 32'h0; m_cnt = 0; m_err = 0;
    rst_n = 1'b1;
    send(7'b0000011, 5'd2, 5'd3, 5'd0, 3'd3, 7'd0, 32'hFFFFFFF8, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    idle(3);
    check("post_rst_drained", 32'(sb.size()), 32'd0);
    check("post_rst_cnt", 32'(instr_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV64I instruction encoder: packs decoded fields (opcode, rd, rs1, rs2, funct3, funct7, imm) back into 32-bit instruction words using the same field layout `decode` extracts. It is the write-side counterpart of `decode`. It sits between the test/program generator and instruction memory, and produces one encoded word per cycle with an assigned byte address. Immediates are range-checked, and round-trip integrity is guaranteed: `decode(encode(x))` returns the original fields for every legal input.

## Interface
- `RESET_PC`, default `32'h0000_0000`: address given to the first word after reset.
- `CNT_W`, default `16`: width of `instr_cnt` and `err_cnt`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: field bundle valid.
- `in_ready` out 1: encoder can accept; combinational, `in_ready = !out_valid || out_ready`.
- `in_opcode` in 7, `in_rd` in 5, `in_rs1` in 5, `in_rs2` in 5, `in_funct3` in 3, `in_funct7` in 7: instruction fields.
- `in_imm` in 32: immediate, sign-extended to 32 bits, as `decode` produces it.
- `pc_load` in 1, `pc_value` in 32: synchronous address reload.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_instr` out 32: encoded word.
- `out_addr` out 32: byte address of `out_instr`.
- `out_err` out 1: sideband on the current output word; the word's fields were illegal.
- `instr_cnt` out `CNT_W`: words accepted; wraps.
- `err_cnt` out `CNT_W`: words flagged; saturates at all-ones.

## Operation
- **Accept:** `in_valid && in_ready`. At acceptance, register the encoded word, address, and error flag; then `out_valid` goes to 1.
- **Output register:** a single entry with states EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `out_ready` with no accept.
  - FULL → FULL on simultaneous transfer and accept.
- **Stall:** while `out_valid && !out_ready`, all outputs are held stable.
- **Encoding by opcode:**
  - R (`0110011`): `{funct7, rs2, rs1, funct3, rd, opcode}`.
  - I (`0000011`, `0010011`, `1100111`, `1110011`): `{imm[11:0], rs1, funct3, rd, opcode}`.
    - OP-IMM with funct3 `001`/`101`: `{funct7[6:1], imm[5:0], rs1, funct3, rd, opcode}` (6-bit RV64 shamt).
  - S (`0100011`): `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B (`1100011`): `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`.
  - U (`0110111`, `0010111`): `{imm[31:12], rd, opcode}`.
  - J (`1101111`): `{imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}`.
  - Any other opcode: emit `32'h0000_0013` (NOP).
  - Unused fields are ignored.
- **Range rules** (violation sets `out_err`; the word is still emitted with truncated bits):
  - I, S: `imm[31:11]` all equal.
  - Shifts: `imm[31:6]==0`.
  - B: `imm[31:12]` all equal and `imm[0]==0`.
  - J: `imm[31:20]` all equal and `imm[0]==0`.
  - U: `imm[11:0]==0`.
  - Unknown opcode: error.
- **Address:** an internal `pc` register holds the next address.
  - On accept: `out_addr <= pc`, `pc <= pc+4` (wraps mod 2^32).
  - `pc_load` alone: `pc <= pc_value`.
  - `pc_load` together with accept: the load wins. The accepted word gets `out_addr = pc_value` and `pc <= pc_value+4`.
  - `pc_value[1:0]` is forced to `00`.
- **Counters:**
  - `instr_cnt` increments on every accept.
  - `err_cnt` increments on every flagged accept.

## Timing
- Latency is 1 cycle: fields accepted at edge N appear on `out_*` after edge N.
- Throughput is 1 word/cycle when `out_ready` is held high.
- `in_ready` has a combinational path from `out_ready`; there are no other combinational input-to-output paths.
- Reset values:
  - `out_valid=0`, `out_instr=0`, `out_addr=0`, `out_err=0`
  - `pc=RESET_PC`, `instr_cnt=0`, `err_cnt=0`
- Reset mid-stall: the held word is dropped and not re-emitted. `in_ready` reads 1 in the first cycle after reset (since `out_valid=0`).
- `out_err` is valid only while `out_valid=1`.

## Configuration
- `ENC_RANGE_CHECK_EN` defined: range rules are enforced, and `out_err`/`err_cnt` are live.
- Not defined:
  - No checking logic is built.
  - `out_err` is tied 0 and `err_cnt` is tied 0.
  - Immediates are truncated silently.
  - Unknown opcodes still emit NOP.

## Test plan
- **Legal fields, `out_ready=1`, back-to-back from reset:**
  - ADD x1,x1,x2 → `0x002080b3`
  - ADDI x5,x4,100 → `0x06420293`
  - LW x7,8(x6) → `0x00832383`
  - SW x9,12(x8) → `0x00942623`
  - BEQ x10,x11,16 → `0x00b50863`
  - Expected: addresses 0,4,8,12,16; `instr_cnt=5`; `out_err=0`. Feed each word to `decode` and confirm identical fields.
- **Range errors (`ENC_RANGE_CHECK_EN` defined):**
  - ADDI x0,x0,imm `0x800` → `out_instr=0x80000013`, `out_err=1`, `err_cnt=1`.
  - JAL x1 with imm `0x5` → `out_err=1`.
  - Opcode `0x7f` → `0x00000013`, `out_err=1`.
  - Without the macro: all three give `out_err=0`, `err_cnt=0`.
- **Backpressure:** hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0`; `out_instr`/`out_addr` stable. Release → the next word is accepted that same cycle, with no loss or duplication.
- **`pc_load`:**
  - Load `0x1000` idle, then accept → `out_addr=0x1000`, next `0x1004`.
  - `pc_load` of `0x2003` coincident with accept → `out_addr=0x2000`, next `0x2004`.
- **Reset mid-stall:** assert `rst_n=0` while FULL with `out_ready=0`. At the next edge: `out_valid=0`, `out_instr=0`, counters 0; the first word after reset gets `out_addr=RESET_PC`.
